// File: rtl/axi4_lite_reg_master.sv
// AXI4-Lite initiator: turns a command/response stream into single register reads and writes.
// Define AXI4_REG_MASTER_TIMEOUT_EN to build the debug-recovery wait timeout (TIMEOUT_CYCLES_P).
module axi4_lite_reg_master #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ADDR_WIDTH_P = 16,
    parameter int TIMEOUT_CYCLES_P = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [AXI_ADDR_WIDTH_P-1:0]   awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [AXI_DATA_WIDTH_P-1:0]   wdata,
    output logic [AXI_DATA_WIDTH_P/8-1:0] wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [AXI_ADDR_WIDTH_P-1:0]   araddr,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [AXI_DATA_WIDTH_P-1:0]   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int StrbW = AXI_DATA_WIDTH_P / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_e;

    state_e                      state_q, state_d;
    logic                        awValid_q, awValid_d;
    logic                        wValid_q, wValid_d;
    logic                        arValid_q, arValid_d;
    logic                        bReady_q, bReady_d;
    logic                        rReady_q, rReady_d;
    logic                        rspValid_q, rspValid_d;
    logic                        isWrite_q, isWrite_d;
    logic [AXI_ADDR_WIDTH_P-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH_P-1:0] wData_q, wData_d;
    logic [StrbW-1:0]            wStrb_q, wStrb_d;
    logic [AXI_DATA_WIDTH_P-1:0] rData_q, rData_d;
    logic [1:0]                  resp_q, resp_d;

`ifdef AXI4_REG_MASTER_TIMEOUT_EN
    localparam int                WaitW       = $clog2(TIMEOUT_CYCLES_P);
    localparam logic [WaitW-1:0]  TimeoutLast = WaitW'(TIMEOUT_CYCLES_P - 1);
    logic [WaitW-1:0]             waitCnt_q, waitCnt_d;
    logic                         waitState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            awValid_q  <= 1'b0;
            wValid_q   <= 1'b0;
            arValid_q  <= 1'b0;
            bReady_q   <= 1'b0;
            rReady_q   <= 1'b0;
            rspValid_q <= 1'b0;
            isWrite_q  <= 1'b0;
            addr_q     <= '0;
            wData_q    <= '0;
            wStrb_q    <= '0;
            rData_q    <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            awValid_q  <= awValid_d;
            wValid_q   <= wValid_d;
            arValid_q  <= arValid_d;
            bReady_q   <= bReady_d;
            rReady_q   <= rReady_d;
            rspValid_q <= rspValid_d;
            isWrite_q  <= isWrite_d;
            addr_q     <= addr_d;
            wData_q    <= wData_d;
            wStrb_q    <= wStrb_d;
            rData_q    <= rData_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awValid_d  = awValid_q;
        wValid_d   = wValid_q;
        arValid_d  = arValid_q;
        bReady_d   = bReady_q;
        rReady_d   = rReady_q;
        rspValid_d = rspValid_q;
        isWrite_d  = isWrite_q;
        addr_d     = addr_q;
        wData_d    = wData_q;
        wStrb_d    = wStrb_q;
        rData_d    = rData_q;
        resp_d     = resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    isWrite_d = cmd_write;
                    addr_d    = cmd_addr;
                    wData_d   = cmd_wdata;
                    wStrb_d   = cmd_wstrb;
                    rData_d   = '0;
                    resp_d    = '0;
                    if (cmd_write) begin
                        awValid_d = 1'b1;
                        wValid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arValid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            // AW and W retire independently; a low valid means that channel is already done.
            WR: begin
                if (awready) begin
                    awValid_d = 1'b0;
                end
                if (wready) begin
                    wValid_d = 1'b0;
                end
                if ((!awValid_q || awready) && (!wValid_q || wready)) begin
                    bReady_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    resp_d     = bresp;
                    bReady_d   = 1'b0;
                    rspValid_d = 1'b1;
                    state_d    = RSP;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arValid_d = 1'b0;
                    rReady_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rData_d    = rdata;
                    resp_d     = rresp;
                    rReady_d   = 1'b0;
                    rspValid_d = 1'b1;
                    state_d    = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI4_REG_MASTER_TIMEOUT_EN
        // A stalled slave is abandoned only if no normal transition happens this cycle.
        waitState = (state_q == WR) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);
        if (waitState && (state_d == state_q) && (waitCnt_q == TimeoutLast)) begin
            awValid_d  = 1'b0;
            wValid_d   = 1'b0;
            arValid_d  = 1'b0;
            bReady_d   = 1'b0;
            rReady_d   = 1'b0;
            rspValid_d = 1'b1;
            resp_d     = 2'b10;
            rData_d    = '0;
            state_d    = RSP;
        end
        if (state_d != state_q) begin
            waitCnt_d = '0;
        end else if (waitState) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end else begin
            waitCnt_d = waitCnt_q;
        end
`endif
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rspValid_q;
    assign rsp_write = isWrite_q;
    assign rsp_rdata = rData_q;
    assign rsp_resp  = resp_q;
    assign awaddr    = addr_q;
    assign awvalid   = awValid_q;
    assign wdata     = wData_q;
    assign wstrb     = wStrb_q;
    assign wvalid    = wValid_q;
    assign bready    = bReady_q;
    assign araddr    = addr_q;
    assign arvalid   = arValid_q;
    assign rready    = rReady_q;

endmodule

// File: tb/tb_axi4_lite_reg_master.sv
// Bench for axi4_lite_reg_master: reactive AXI slave with programmable delays plus a
// transaction-level register model; directed scenarios followed by randomized traffic.
module tb_axi4_lite_reg_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axi4_lite_reg_master #(
        .AXI_DATA_WIDTH_P(DW),
        .AXI_ADDR_WIDTH_P(AW),
        .TIMEOUT_CYCLES_P(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       awDelay = 1, wDelay = 1, bDelay = 0, arDelay = 1, rDelay = 0;
    logic [1:0] bRespSel = 2'b00, rRespSel = 2'b00;
    bit       arStall = 1'b0, allowDrop = 1'b0;
    int       awHsCnt = 0, wHsCnt = 0, bHsCnt = 0, arHsCnt = 0, rHsCnt = 0;
    logic [DW-1:0] slvMem [logic [AW-1:0]];
    logic [DW-1:0] refMem [logic [AW-1:0]];
    int       dropViol = 0, stabViol = 0, skewCyc = 0, rWaitCyc = 0, arHighCyc = 0;
    logic        expW;
    logic [DW-1:0] expData;
    logic [1:0]  expResp;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mergeStrb(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                               input logic [SW-1:0] s);
        logic [DW-1:0] r = old;
        for (int i = 0; i < SW; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Slave: each ready/valid is raised at a negedge, so a handshake is known before the posedge.
    initial begin : slave
        int awCnt, wCnt, bCnt, arCnt, rCnt;
        bit awGot, wGot, arGot, bHs, rHs;
        logic [AW-1:0] slvAw, slvAr;
        logic [DW-1:0] slvWd;
        logic [SW-1:0] slvWs;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
        awGot = 0; wGot = 0; arGot = 0; bHs = 0; rHs = 0;
        slvAw = 0; slvAr = 0; slvWd = 0; slvWs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
                awGot = 0; wGot = 0; arGot = 0; bHs = 0; rHs = 0;
                continue;
            end
            if (bHs) begin
                bvalid = 0; bHsCnt++;
            end else if (!bvalid && awGot && wGot) begin
                if (bCnt >= bDelay) begin
                    bvalid = 1; bresp = bRespSel;
                    slvMem[slvAw] = mergeStrb(slvMem.exists(slvAw) ? slvMem[slvAw] : '0, slvWd, slvWs);
                    awGot = 0; wGot = 0; bCnt = 0;
                end else bCnt++;
            end
            if (rHs) begin
                rvalid = 0; rHsCnt++;
            end else if (!rvalid && arGot) begin
                if (rCnt >= rDelay) begin
                    rvalid = 1; rresp = rRespSel;
                    rdata = slvMem.exists(slvAr) ? slvMem[slvAr] : '0;
                    arGot = 0; rCnt = 0;
                end else rCnt++;
            end
            if (awready) awready = 0;
            else if (awvalid && !awGot) begin
                if (awCnt >= awDelay) begin
                    awready = 1; awGot = 1; slvAw = awaddr; awCnt = 0; awHsCnt++;
                end else awCnt++;
            end
            if (wready) wready = 0;
            else if (wvalid && !wGot) begin
                if (wCnt >= wDelay) begin
                    wready = 1; wGot = 1; slvWd = wdata; slvWs = wstrb; wCnt = 0; wHsCnt++;
                end else wCnt++;
            end
            if (arready) arready = 0;
            else if (arvalid && !arGot && !arStall) begin
                if (arCnt >= arDelay) begin
                    arready = 1; arGot = 1; slvAr = araddr; arCnt = 0; arHsCnt++;
                end else arCnt++;
            end
            bHs = bvalid && bready;
            rHs = rvalid && rready;
        end
    end

    // Protocol monitor: valids hold until handshake, payloads stay stable, response held until taken.
    initial begin : monitor
        logic pAw, pW, pAr, pB, pR, pRsp;
        logic pAwHs, pWHs, pArHs, pBHs, pRHs, pRspHs;
        logic [AW-1:0] pAwA, pArA;
        logic [DW-1:0] pWd, pRd;
        logic [SW-1:0] pWs;
        logic [2:0] pRspF;
        pAw = 0; pW = 0; pAr = 0; pB = 0; pR = 0; pRsp = 0;
        pAwHs = 0; pWHs = 0; pArHs = 0; pBHs = 0; pRHs = 0; pRspHs = 0;
        pAwA = 0; pArA = 0; pWd = 0; pRd = 0; pWs = 0; pRspF = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (!allowDrop) begin
                    if ((pAw && !pAwHs && !awvalid) || (pW && !pWHs && !wvalid) ||
                        (pAr && !pArHs && !arvalid) || (pB && !pBHs && !bready) ||
                        (pR && !pRHs && !rready) || (pRsp && !pRspHs && !rsp_valid)) dropViol++;
                end
                if ((pAw && awvalid && awaddr !== pAwA) || (pAr && arvalid && araddr !== pArA) ||
                    (pW && wvalid && (wdata !== pWd || wstrb !== pWs)) ||
                    (pRsp && rsp_valid && (rsp_rdata !== pRd || {rsp_write, rsp_resp} !== pRspF)))
                    stabViol++;
                if (awvalid && !wvalid) skewCyc++;
                if (rready && !rvalid) rWaitCyc++;
                if (arvalid) arHighCyc++;
            end
            pAw = awvalid; pW = wvalid; pAr = arvalid; pB = bready; pR = rready; pRsp = rsp_valid;
            pAwHs = awvalid && awready; pWHs = wvalid && wready; pArHs = arvalid && arready;
            pBHs = bvalid && bready; pRHs = rvalid && rready; pRspHs = rsp_valid && rsp_ready;
            pAwA = awaddr; pArA = araddr; pWd = wdata; pWs = wstrb;
            pRd = rsp_rdata; pRspF = {rsp_write, rsp_resp};
        end
    end

    task automatic modelCmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        expW = w;
        if (w) begin
            expData = '0;
            expResp = bRespSel;
            refMem[a] = mergeStrb(refMem.exists(a) ? refMem[a] : '0, d, s);
        end else begin
            expData = refMem.exists(a) ? refMem[a] : '0;
            expResp = rRespSel;
        end
    endtask

    task automatic checkRsp(input string tag);
        checkOutput({tag, ".write"}, 64'(rsp_write), 64'(expW));
        checkOutput({tag, ".rdata"}, 64'(rsp_rdata), 64'(expData));
        checkOutput({tag, ".resp"}, 64'(rsp_resp), 64'(expResp));
    endtask

    task automatic sendCmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output int acceptCyc);
        int guard = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        #1;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk); #1; guard++;
        end
        checkOutput("cmdAccepted", 64'(cmd_ready), 64'd1);
        acceptCyc = cyc;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic waitRsp(output int rspCyc);
        int guard = 0;
        #1;
        while (!rsp_valid && guard < 300) begin
            @(negedge clk); #1; guard++;
        end
        checkOutput("rspArrived", 64'(rsp_valid), 64'd1);
        rspCyc = cyc;
    endtask

    task automatic releaseRsp(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic applyStimulus(input string tag, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [SW-1:0] s,
                                 input int hold, output int lat, output logic [DW-1:0] gotData);
        int acc, rc;
        int aw0 = awHsCnt, w0 = wHsCnt, b0 = bHsCnt, ar0 = arHsCnt, r0 = rHsCnt;
        logic [19:0] expHs;
        modelCmd(w, a, d, s);
        sendCmd(w, a, d, s, acc);
        waitRsp(rc);
        lat = rc - acc;
        gotData = rsp_rdata;
        checkRsp(tag);
        releaseRsp(hold);
        expHs = w ? {4'd1, 4'd1, 4'd1, 4'd0, 4'd0} : {4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
        checkOutput({tag, ".handshakes"},
                    64'({4'(awHsCnt - aw0), 4'(wHsCnt - w0), 4'(bHsCnt - b0),
                         4'(arHsCnt - ar0), 4'(rHsCnt - r0)}), 64'(expHs));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int lat, acc, rc, viol, guard;
        logic [DW-1:0] gd;
        logic [AW-1:0] addrPool [8];
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        for (int i = 0; i < 8; i++) addrPool[i] = AW'($urandom_range(0, 16'h3FFF) << 2);
        addrPool[0] = 16'h0008;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
        checkOutput("reset.regs", 64'({awaddr, wstrb, rsp_write, rsp_resp}), 64'd0);
        checkOutput("reset.data", 64'({wdata, rsp_rdata}), 64'd0);
        checkOutput("reset.cmdReady", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        $display("[TB] write then read back 0x0008");
        applyStimulus("t1write", 1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 0, lat, gd);
        checkOutput("t1.latency", 64'(lat), 64'd4);
        applyStimulus("t1read", 1'b0, 16'h0008, 32'h0, 4'h0, 0, lat, gd);
        checkOutput("t1.readback", 64'(gd), 64'hDEADBEEF);

        $display("[TB] W channel completes 3 cycles before AW");
        awDelay = 4; wDelay = 1; bRespSel = 2'b01;
        skewCyc = 0;
        applyStimulus("t2write", 1'b1, 16'h0008, 32'h1234ABCD, 4'b0101, 1, lat, gd);
        checkOutput("t2.skewCycles", 64'(skewCyc), 64'd3);
        awDelay = 1; bRespSel = 2'b00;

        $display("[TB] read with slow SLVERR data");
        rDelay = 6; rRespSel = 2'b10; rWaitCyc = 0;
        applyStimulus("t3read", 1'b0, 16'h0008, 32'h0, 4'h0, 0, lat, gd);
        checkOutput("t3.rreadyWait", 64'(rWaitCyc), 64'd6);
        rDelay = 0; rRespSel = 2'b00;

        $display("[TB] response backpressure with next command waiting");
        rRespSel = 2'b11;
        modelCmd(1'b0, 16'h0008, 32'h0, 4'h0);
        sendCmd(1'b0, 16'h0008, 32'h0, 4'h0, acc);
        waitRsp(rc);
        checkRsp("t4read");
        rRespSel = 2'b00;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0010; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        viol = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (cmd_ready || !rsp_valid) viol++;
        end
        checkOutput("t4.heldCycles", 64'(viol), 64'd0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        #1;
        checkOutput("t4.acceptNext", 64'(cmd_ready), 64'd1);
        modelCmd(1'b1, 16'h0010, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        cmd_valid = 0;
        waitRsp(rc);
        checkRsp("t4write");
        releaseRsp(0);

        $display("[TB] reset pulse while waiting for B");
        bDelay = 10;
        sendCmd(1'b1, 16'h0014, 32'h55AA55AA, 4'hF, acc);
        guard = 0;
        while (!bready && guard < 50) begin
            @(negedge clk); guard++;
        end
        checkOutput("t5.reachedWrResp", 64'(bready), 64'd1);
        @(negedge clk);
        #3 rst_n = 0;
        #1;
        checkOutput("t5.resetOutputs", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1;
        bDelay = 0;
        viol = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (rsp_valid || !cmd_ready) viol++;
        end
        checkOutput("t5.quietAfterReset", 64'(viol), 64'd0);
        @(negedge clk);
        applyStimulus("t5after", 1'b0, 16'h0014, 32'h0, 4'h0, 0, lat, gd);
        applyStimulus("t5write", 1'b1, 16'h0014, 32'h0BADF00D, 4'b1100, 0, lat, gd);

`ifdef AXI4_REG_MASTER_TIMEOUT_EN
        $display("[TB] read with arready stuck low");
        arStall = 1; allowDrop = 1; arHighCyc = 0;
        sendCmd(1'b0, 16'h0008, 32'h0, 4'h0, acc);
        waitRsp(rc);
        checkOutput("t6.resp", 64'(rsp_resp), 64'd2);
        checkOutput("t6.rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("t6.arvalidCycles", 64'(arHighCyc), 64'd16);
        releaseRsp(0);
        arStall = 0; allowDrop = 0;
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 60; n++) begin
            logic w;
            logic [AW-1:0] a;
            awDelay = $urandom_range(1, 4); wDelay = $urandom_range(1, 4);
            bDelay = $urandom_range(0, 3); arDelay = $urandom_range(1, 4);
            rDelay = $urandom_range(0, 5);
            bRespSel = 2'($urandom_range(0, 3)); rRespSel = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = addrPool[$urandom_range(0, 7)];
            applyStimulus("rand", w, a, $urandom, SW'($urandom), $urandom_range(0, 3), lat, gd);
        end

        checkOutput("validDrops", 64'(dropViol), 64'd0);
        checkOutput("payloadStability", 64'(stabViol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_master.md
Name: axi4_lite_reg_master

Overview:
AXI4-Lite initiator that turns a simple command/response stream into single register reads and writes on an AXI4-Lite bus. Drives the AXI slave register banks generated by pyreg from local controllers, test sequencers and debug bridges. Exactly one transaction is outstanding at a time. Every AXI response, including error responses, is returned on the response stream.

Parameters:
AXI_DATA_WIDTH_P, 32, AXI data width in bits; a multiple of 8.
AXI_ADDR_WIDTH_P, 16, AXI address width in bits.
TIMEOUT_CYCLES_P, 1024, timeout limit in cycles; used only when the optional feature is compiled in; must be >= 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AXI_ADDR_WIDTH_P  byte address
cmd_wdata  in  AXI_DATA_WIDTH_P  write data
cmd_wstrb  in  AXI_DATA_WIDTH_P/8  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  AXI_DATA_WIDTH_P  read data; 0 for writes
rsp_resp  out  2  AXI response code
awaddr, awvalid, awready  out/out/in  ADDR/1/1  write address channel
wdata, wstrb, wvalid, wready  out/out/out/in  DATA/DATA/8/1/1  write data channel
bresp, bvalid, bready  in/in/out  2/1/1  write response channel
araddr, arvalid, arready  out/out/in  ADDR/1/1  read address channel
rdata, rresp, rvalid, rready  in/in/in/out  DATA/2/1/1  read data channel

Behaviour:
- Single clock clk; rst_n is asynchronous, active-low.
- Reset:
  - state IDLE.
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid all 0.
  - All address, data and response registers 0.
- cmd_ready = (state == IDLE); combinational from the state register.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - On cmd_valid & cmd_ready, latch the command.
  - Write: set awvalid and wvalid to 1 next cycle and go to WR.
  - Read: set arvalid to 1 next cycle and go to RD_ADDR.
- WR:
  - awvalid clears on the cycle after the awvalid&awready handshake; wvalid clears on the cycle after wvalid&wready; each independently.
  - AW and W may complete in the same cycle or in either order.
  - Once both have completed, go to WR_RESP.
  - awaddr, wdata and wstrb stay stable while their valid is high.
- WR_RESP: bready = 1. On bvalid, capture bresp, clear bready and go to RSP.
- RD_ADDR: hold arvalid until arready; then clear arvalid, set rready = 1 and go to RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata and rresp, clear rready and go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* fields stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, clear rsp_valid and return to IDLE.
  - The next command can be accepted on the following cycle.
- Valid signals never drop before their handshake, except on timeout.
- bresp/rresp are passed through unmodified (OKAY, EXOKAY, SLVERR, DECERR).
- Latency against a slave that responds in one cycle per channel:
  - command accepted in cycle N;
  - awvalid/wvalid high at N+1;
  - awready/wready at N+2;
  - bvalid at N+3;
  - rsp_valid at N+4.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously); the pending command is discarded with no response.

Optional Feature:
Macro AXI4_REG_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every state entry and counts cycles spent in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES_P: all AXI valid/ready outputs drop to 0, rsp_resp = 2'b10 (SLVERR), rsp_rdata = 0, and the FSM goes to RSP.
  - This deliberately breaks AXI handshake rules; it is for debug recovery only.
- Not defined: no counter is built; the block waits indefinitely and TIMEOUT_CYCLES_P is ignored.

Test Plan:
- Write addr 0x0008, data 0xDEADBEEF, strb 0xF; slave answers OKAY -> AW and W handshake, bready at the bvalid cycle, rsp_valid at N+4 with rsp_resp 0 and rsp_write 1; a following read of 0x0008 returns rsp_rdata 0xDEADBEEF.
- wready asserted 3 cycles before awready -> wvalid clears after its handshake while awvalid stays high; exactly one B handshake; one response.
- Read with rvalid delayed 6 cycles, rresp 2'b10 -> rready held high for all 6 cycles; rsp_resp 2'b10 with rsp_rdata passed through.
- rsp_ready held low for 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready 0 throughout; the next command is accepted in the cycle after rsp_ready.
- rst_n pulsed low while in WR_RESP -> all valids/readies 0 during reset; no rsp_valid after release; a new command completes normally.
- AXI4_REG_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES_P = 16, arready tied 0 -> arvalid drops after 16 cycles and the response carries rsp_resp 2'b10, rsp_rdata 0.
